// File: rtl/lane_capture_fifo.sv
// lane_capture_fifo
//
// Receive-side endpoint for the 4-lane registered flop-chain transport.
// The chain delivers one word per cycle and cannot be stalled, so every word
// is captured into a small FIFO. The FIFO head goes to a downstream consumer
// over a valid/ready handshake. Each consumed word returns one credit pulse,
// which lets the sender keep no more than DEPTH words in flight.
//
// Parameters:
//   WIDTH  lane count / data word width in bits
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  occupancy counter width, log2(DEPTH)+1
//
// Ports:
//   clk         single clock, all state updates on the rising edge
//   rst         synchronous active-high reset; discards buffered words
//   in_valid    a word is present on in_data this cycle
//   in_data     captured lane data
//   out_valid   FIFO head is valid (count != 0)
//   out_data    FIFO head word, read combinationally from storage
//   out_ready   consumer accepts the head this cycle
//   credit_ret  one-cycle pulse in the cycle after each pop
//   count       current occupancy, 0..DEPTH
//   overflow    sticky flag: a word arrived while full with no pop

module lane_capture_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             credit_ret,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             credit_q;
  logic             overflow_q;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Full and empty come from the occupancy count alone, so the pointers can
  // wrap naturally without an extra wrap bit.
  // A push into a full FIFO is still accepted when a pop frees the head slot
  // at the same edge; otherwise the word is dropped and flagged.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_CNT);
    pop   = !empty && out_ready;
    push  = in_valid && (!full || pop);
    drop  = in_valid && full && !pop;
  end

  // Storage has no reset: its contents are meaningless while the matching
  // count is zero. Writes are suppressed during reset so a word arriving
  // alongside rst never lands in the buffer.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy, the registered credit pulse and the sticky overflow
  // flag. Reset wins over everything else, so words discarded by reset never
  // produce credits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      credit_q <= pop;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // The head is read straight from storage, so a word written at one edge is
  // visible right after that edge. There is deliberately no bypass from
  // in_data: an empty FIFO never shows same-cycle input.
  always_comb begin
    out_valid  = !empty;
    out_data   = mem[rd_ptr];
    credit_ret = credit_q;
    count      = count_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_lane_capture_fifo.sv
// tb_lane_capture_fifo
//
// Directed test of lane_capture_fifo. The stimulus process pushes each word it
// expects to come out into a scoreboard queue; a separate monitor pops and
// compares whenever the DUT hands a word over (out_valid && out_ready).
// Inputs change 1 time unit after the rising edge, status checks happen at the
// same point, and the monitor samples on the falling edge.

module tb_lane_capture_fifo;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       credit_ret;
  logic [2:0] count;
  logic       overflow;

  int passCount  = 0;
  int checkCount = 0;
  int creditSeen = 0;
  int creditBase = 0;
  logic [3:0] sbQueue [$];

  lane_capture_fifo #(
    .WIDTH(4),
    .DEPTH(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .credit_ret(credit_ret),
    .count(count),
    .overflow(overflow)
  );

  // 10 time-unit clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends on its own
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let the rising edge happen, then return to idle
  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] d,
                               input logic rdy);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b0;
  endtask

  // Push a word the FIFO is expected to accept and later deliver
  task automatic pushExpected(input logic [3:0] d, input logic rdy);
    sbQueue.push_back(d);
    applyStimulus(1'b0, 1'b1, d, rdy);
  endtask

  task automatic popCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    end
  endtask

  task automatic doReset();
    sbQueue.delete();
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
  endtask

  // Monitor: scoreboard compare on every handshake, credit pulse counting
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbQueue.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_word: actual=%0h required=none", out_data);
      end else begin
        checkOutput("out_data_order", int'(out_data), int'(sbQueue.pop_front()));
      end
    end
    if (credit_ret === 1'b1) begin
      creditSeen++;
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b0;

    // Reset held for two cycles with a word on the input
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 4'hF, 1'b0);
      checkOutput("reset_count", int'(count), 0);
      checkOutput("reset_out_valid", int'(out_valid), 0);
      checkOutput("reset_credit", int'(credit_ret), 0);
      checkOutput("reset_overflow", int'(overflow), 0);
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("reset_no_capture", int'(out_valid), 0);

    // Single word, then one pop and one credit pulse
    creditBase = creditSeen;
    pushExpected(4'hA, 1'b0);
    checkOutput("single_out_valid", int'(out_valid), 1);
    checkOutput("single_out_data", int'(out_data), 'hA);
    checkOutput("single_count", int'(count), 1);
    checkOutput("single_credit_before", int'(credit_ret), 0);
    popCycles(1);
    checkOutput("single_count_after", int'(count), 0);
    checkOutput("single_valid_after", int'(out_valid), 0);
    checkOutput("single_credit_pulse", int'(credit_ret), 1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkOutput("single_credit_end", int'(credit_ret), 0);
    checkOutput("single_credit_total", creditSeen - creditBase, 1);

    // Fill, partial drain, refill across the pointer wrap, full drain
    creditBase = creditSeen;
    for (int i = 1; i <= 4; i++) begin
      pushExpected(4'(i), 1'b0);
    end
    checkOutput("fill_count", int'(count), 4);
    popCycles(2);
    checkOutput("partial_count", int'(count), 2);
    pushExpected(4'h5, 1'b0);
    pushExpected(4'h6, 1'b0);
    checkOutput("refill_count", int'(count), 4);
    popCycles(4);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("wrap_count_empty", int'(count), 0);
    checkOutput("wrap_credit_total", creditSeen - creditBase, 6);
    checkOutput("wrap_overflow", int'(overflow), 0);
    checkOutput("wrap_sb_drained", sbQueue.size(), 0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) begin
      pushExpected(4'(i), 1'b0);
    end
    pushExpected(4'h7, 1'b1);
    checkOutput("fullpp_count", int'(count), 4);
    checkOutput("fullpp_overflow", int'(overflow), 0);
    checkOutput("fullpp_head", int'(out_data), 2);
    popCycles(4);
    checkOutput("fullpp_count_empty", int'(count), 0);
    checkOutput("fullpp_sb_drained", sbQueue.size(), 0);

    // Overflow: a fifth word with no pop is dropped and flagged
    for (int i = 1; i <= 4; i++) begin
      pushExpected(4'(i), 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 4'hC, 1'b0);
    checkOutput("ovf_set", int'(overflow), 1);
    checkOutput("ovf_count", int'(count), 4);
    checkOutput("ovf_head", int'(out_data), 1);
    popCycles(4);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("ovf_sticky", int'(overflow), 1);
    checkOutput("ovf_count_empty", int'(count), 0);
    checkOutput("ovf_sb_drained", sbQueue.size(), 0);
    doReset();
    checkOutput("ovf_cleared", int'(overflow), 0);

    // Mid-operation reset with the consumer ready
    for (int i = 1; i <= 3; i++) begin
      pushExpected(4'(i), 1'b0);
    end
    checkOutput("mid_count", int'(count), 3);
    creditBase = creditSeen;
    sbQueue.delete();
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
    checkOutput("mid_count_reset", int'(count), 0);
    checkOutput("mid_valid_reset", int'(out_valid), 0);
    checkOutput("mid_credit_reset", int'(credit_ret), 0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("mid_credit_after", int'(credit_ret), 0);
    checkOutput("mid_credit_total", creditSeen - creditBase, 0);
    pushExpected(4'h9, 1'b0);
    checkOutput("mid_first_word", int'(out_data), 9);
    popCycles(1);
    checkOutput("mid_sb_drained", sbQueue.size(), 0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
